aes_inv_shiftrows_buffer: RTL and testbench

- Byte-serial AES decryption front end that sits directly upstream of the inverse S-box stage.
- Collects 16-byte AES state blocks in column-major order (byte index i = row + 4*col).
- Re-emits each block permuted by InvShiftRows, one byte per cycle, so the inverse S-box can consume the stream unchanged.
- Ping-pong double buffering sustains 1 byte/cycle with both sides streaming.

---
 rtl/aes_inv_shiftrows_buffer_if.sv | 21 ++
 rtl/aes_inv_shiftrows_buffer.sv | 88 ++++++++
 tb/tb_aes_inv_shiftrows_buffer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_inv_shiftrows_buffer_if.sv
// Byte-stream handshake bundle between the block collector and its neighbours.
// The master side supplies input bytes and output backpressure.
interface aes_inv_shiftrows_buffer_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_last
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_last
   );
endinterface

// File: rtl/aes_inv_shiftrows_buffer.sv
// Ping-pong 16-byte block buffer that re-emits each AES state in (Inv)ShiftRows
// order, one byte per cycle, ahead of the inverse S-box.
module aes_inv_shiftrows_buffer #(
   parameter bit INVERSE = 1'b1
) (
   input logic                         clk,
   input logic                         rst,
   input logic                         clear,
   aes_inv_shiftrows_buffer_if.slave   bus
);
   localparam int unsigned DATA_W = 8;
   localparam int unsigned DEPTH  = 16;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned BANKS  = 2;

   logic [BANKS-1:0]  full;
   logic [BANKS-1:0]  full_nxt;
   logic              wr_sel;
   logic              rd_sel;
   logic [CNT_W-1:0]  wr_cnt;
   logic [CNT_W-1:0]  rd_cnt;
   logic [DATA_W-1:0] bank [BANKS][DEPTH];

   logic              wr_fire;
   logic              rd_fire;
   logic              wr_last;
   logic              rd_last;
   logic [1:0]        rd_row;
   logic [1:0]        rd_col;
   logic [1:0]        src_col;
   logic [CNT_W-1:0]  src_idx;

   // Handshake status depends only on registered flags and selects.
   assign bus.in_ready  = ~full[wr_sel];
   assign bus.out_valid = full[rd_sel];

   assign wr_fire = bus.in_valid & ~full[wr_sel];
   assign rd_fire = full[rd_sel] & bus.out_ready;
   assign wr_last = (wr_cnt == CNT_W'(DEPTH - 1));
   assign rd_last = (rd_cnt == CNT_W'(DEPTH - 1));

   // Output byte k sits at row k[1:0], column k[3:2]; fetch it from the rotated column.
   assign rd_row  = rd_cnt[1:0];
   assign rd_col  = rd_cnt[3:2];
   assign src_col = INVERSE ? 2'(rd_col - rd_row) : 2'(rd_col + rd_row);
   assign src_idx = {src_col, rd_row};

   assign bus.out_data = full[rd_sel] ? bank[rd_sel][src_idx] : DATA_W'(0);
   assign bus.out_last = full[rd_sel] & rd_last;

   // Fill of one bank and drain of the other never target the same flag.
   always_comb begin
      full_nxt = full;
      if (wr_fire && wr_last) full_nxt[wr_sel] = 1'b1;
      if (rd_fire && rd_last) full_nxt[rd_sel] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full   <= '0;
         wr_sel <= 1'b0;
         rd_sel <= 1'b0;
         wr_cnt <= '0;
         rd_cnt <= '0;
      end else if (clear) begin
         full   <= '0;
         wr_sel <= 1'b0;
         rd_sel <= 1'b0;
         wr_cnt <= '0;
         rd_cnt <= '0;
      end else begin
         full <= full_nxt;
         if (wr_fire) begin
            wr_cnt <= wr_cnt + CNT_W'(1);
            if (wr_last) wr_sel <= ~wr_sel;
         end
         if (rd_fire) begin
            rd_cnt <= rd_cnt + CNT_W'(1);
            if (rd_last) rd_sel <= ~rd_sel;
         end
      end
   end

   // Bank storage carries no reset; contents are only observed once a flag is set.
   always_ff @(posedge clk) begin
      if (wr_fire && !clear) bank[wr_sel][wr_cnt] <= bus.in_data;
   end
endmodule

// File: tb/tb_aes_inv_shiftrows_buffer.sv
// Self-checking bench: randomized and directed traffic against a row-rotation
// reference model of (Inv)ShiftRows with an occupancy-based handshake model.
module tb_aes_inv_shiftrows_buffer;
   typedef logic [7:0] blk_t [16];

   logic clk = 1'b0;
   logic rst;
   logic clear;

   aes_inv_shiftrows_buffer_if bus ();
   aes_inv_shiftrows_buffer_if bus_f ();

   aes_inv_shiftrows_buffer #(.INVERSE(1'b1)) dut (
      .clk(clk), .rst(rst), .clear(clear), .bus(bus)
   );

   aes_inv_shiftrows_buffer #(.INVERSE(1'b0)) dut_fwd (
      .clk(clk), .rst(rst), .clear(clear), .bus(bus_f)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int fill_cyc = 0;
   logic [7:0] exp_q[$];
   logic [7:0] part_q[$];
   logic [7:0] got_q[$];
   logic [7:0] src_q[$];
   int         out_cyc[$];
   bit         rnd_valid = 1'b0;

   logic [7:0] inv_seq [16] = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                                8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};
   logic [7:0] fwd_seq [16] = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
                                8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // State as a 4x4 matrix; row r is rotated right (inverse) or left (forward) by r.
   function automatic void perm(input blk_t s, input bit inv, output blk_t o);
      logic [7:0] m [4][4];
      logic [7:0] t;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) m[r][c] = s[r + 4*c];
      for (int r = 0; r < 4; r++) begin
         for (int n = 0; n < r; n++) begin
            if (inv) begin
               t = m[r][3];
               for (int j = 3; j > 0; j--) m[r][j] = m[r][j-1];
               m[r][0] = t;
            end else begin
               t = m[r][0];
               for (int j = 0; j < 3; j++) m[r][j] = m[r][j+1];
               m[r][3] = t;
            end
         end
      end
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) o[r + 4*c] = m[r][c];
   endfunction

   // Check main DUT against the model, update the model, advance one clock.
   task automatic tick();
      int blocks;
      blocks = (exp_q.size() + 15) / 16;
      chk("in_ready",  32'(bus.in_ready),  32'(blocks < 2));
      chk("out_valid", 32'(bus.out_valid), 32'(blocks > 0));
      if (blocks > 0) begin
         chk("out_data", 32'(bus.out_data), 32'(exp_q[0]));
         chk("out_last", 32'(bus.out_last), 32'(exp_q.size() % 16 == 1));
      end else begin
         chk("out_data_idle", 32'(bus.out_data), 32'h0);
         chk("out_last_idle", 32'(bus.out_last), 32'h0);
      end
      if (clear) begin
         exp_q.delete();
         part_q.delete();
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            got_q.push_back(bus.out_data);
            out_cyc.push_back(cyc);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
         end
         if (bus.in_valid && bus.in_ready) begin
            part_q.push_back(bus.in_data);
            if (part_q.size() == 16) begin
               blk_t b;
               blk_t p;
               foreach (b[i]) b[i] = part_q[i];
               perm(b, 1'b1, p);
               foreach (p[i]) exp_q.push_back(p[i]);
               part_q.delete();
               fill_cyc = cyc;
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Offer the head of src_q (gated by rnd_valid when randomizing) for one cycle.
   task automatic step();
      bit acc;
      bus.in_valid = (src_q.size() > 0) && (!rnd_valid || ($urandom_range(0, 3) != 0));
      bus.in_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
      acc = bus.in_valid && bus.in_ready && !clear;
      tick();
      if (acc) void'(src_q.pop_front());
      bus.in_valid = 1'b0;
   endtask

   task automatic drain(input int limit);
      int guard;
      guard = 0;
      while ((src_q.size() > 0 || exp_q.size() > 0) && guard < limit) begin
         step();
         guard++;
      end
      chk("drain_done", 32'(src_q.size() + exp_q.size()), 32'h0);
   endtask

   task automatic push_seq(input int base, input int n);
      for (int i = 0; i < n; i++) src_q.push_back(8'(base + i));
   endtask

   task automatic reset_log();
      got_q.delete();
      out_cyc.delete();
   endtask

   initial begin
      logic [7:0] fwd_got[$];
      blk_t b;
      blk_t p;
      int fi;
      int start;

      rst = 1'b1;
      clear = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data = 8'h00;
      bus.out_ready = 1'b1;
      bus_f.in_valid = 1'b0;
      bus_f.in_data = 8'h00;
      bus_f.out_ready = 1'b1;
      #1;
      chk("rst_in_ready",  32'(bus.in_ready),  32'h1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
      chk("rst_out_last",  32'(bus.out_last),  32'h0);
      chk("rst_out_data",  32'(bus.out_data),  32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Single block, directed sequence and first-byte latency.
      reset_log();
      push_seq(8'h00, 16);
      drain(100);
      chk("single_count", 32'(got_q.size()), 32'd16);
      for (int i = 0; i < 16 && i < got_q.size(); i++) chk("single_seq", 32'(got_q[i]), 32'(inv_seq[i]));
      if (out_cyc.size() > 0) chk("single_latency", 32'(out_cyc[0] - fill_cyc), 32'd1);
      repeat (3) tick();

      // Backpressure: two banks fill, third block waits.
      reset_log();
      bus.out_ready = 1'b0;
      push_seq(8'h00, 48);
      repeat (40) step();
      chk("bp_accepted", 32'(48 - src_q.size()), 32'd32);
      bus.out_ready = 1'b1;
      drain(200);
      chk("bp_count", 32'(got_q.size()), 32'd48);
      if (got_q.size() >= 34) begin
         chk("bp_blk2_b0", 32'(got_q[32]), 32'h20);
         chk("bp_blk2_b1", 32'(got_q[33]), 32'h2D);
      end

      // Streaming four blocks back to back.
      reset_log();
      for (int i = 0; i < 64; i++) src_q.push_back(8'($urandom));
      start = cyc;
      drain(200);
      chk("stream_count", 32'(out_cyc.size()), 32'd64);
      if (out_cyc.size() == 64) begin
         chk("stream_first", 32'(out_cyc[0] - start), 32'd16);
         chk("stream_span",  32'(out_cyc[63] - out_cyc[0]), 32'd63);
      end

      // Flush after a partial block; the offered byte during clear is dropped.
      reset_log();
      push_seq(8'h80, 7);
      repeat (7) step();
      src_q.push_back(8'h99);
      clear = 1'b1;
      step();
      clear = 1'b0;
      src_q.delete();
      repeat (20) tick();
      chk("clear_no_output", 32'(got_q.size()), 32'h0);
      push_seq(8'h10, 16);
      drain(100);
      chk("clear_count", 32'(got_q.size()), 32'd16);
      if (got_q.size() >= 2) chk("clear_b1", 32'(got_q[1]), 32'h1D);

      // Asynchronous reset in the middle of a drain.
      reset_log();
      push_seq(8'h40, 16);
      while (got_q.size() < 5 && cyc < 20000) step();
      #2;
      rst = 1'b1;
      #1;
      chk("mrst_out_valid", 32'(bus.out_valid), 32'h0);
      chk("mrst_in_ready",  32'(bus.in_ready),  32'h1);
      chk("mrst_out_last",  32'(bus.out_last),  32'h0);
      chk("mrst_out_data",  32'(bus.out_data),  32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      part_q.delete();
      src_q.delete();
      reset_log();
      push_seq(8'h50, 16);
      drain(100);
      chk("mrst_count", 32'(got_q.size()), 32'd16);

      // Randomized traffic with random backpressure.
      reset_log();
      rnd_valid = 1'b1;
      for (int i = 0; i < 160; i++) src_q.push_back(8'($urandom));
      for (int i = 0; i < 400; i++) begin
         bus.out_ready = ($urandom_range(0, 2) != 0);
         step();
      end
      bus.out_ready = 1'b1;
      drain(400);
      rnd_valid = 1'b0;
      chk("rand_count", 32'(got_q.size()), 32'd160);

      // Forward build, then chain its output through the inverse build.
      fi = 0;
      for (int n = 0; n < 60; n++) begin
         bus_f.in_valid = (fi < 16);
         bus_f.in_data  = 8'(fi);
         if (bus_f.out_valid && bus_f.out_ready) fwd_got.push_back(bus_f.out_data);
         if (bus_f.in_valid && bus_f.in_ready) fi++;
         @(posedge clk);
         #1;
         cyc++;
      end
      bus_f.in_valid = 1'b0;
      chk("fwd_count", 32'(fwd_got.size()), 32'd16);
      foreach (b[i]) b[i] = 8'(i);
      perm(b, 1'b0, p);
      for (int i = 0; i < 16 && i < fwd_got.size(); i++) begin
         chk("fwd_seq",   32'(fwd_got[i]), 32'(fwd_seq[i]));
         chk("fwd_model", 32'(fwd_got[i]), 32'(p[i]));
      end
      reset_log();
      foreach (fwd_got[i]) src_q.push_back(fwd_got[i]);
      drain(100);
      chk("chain_count", 32'(got_q.size()), 32'd16);
      for (int i = 0; i < 16 && i < got_q.size(); i++) chk("chain_identity", 32'(got_q[i]), 32'(i));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
